uart_tx_ctrl: RTL and testbench

UART transmit controller directly downstream of the 32x8 receive/transmit FIFO. It pops one byte at a time via the FIFO's single-cycle read handshake and serialises it onto the tx line (start, 8 data bits LSB-first, optional parity, stop). The FIFO is clocked from the same clk. This block is the only consumer of the FIFO read port.

---
 rtl/uart_tx_ctrl_pkg.sv | 27 ++
 rtl/uart_tx_ctrl_baud_tick.sv | 38 +++
 rtl/uart_tx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit controller and its baud timer.
package uart_tx_ctrl_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned BAUD_CNT_W           = 16;

    // Parity mode selectors for the PARITY_ODD parameter.
    localparam int unsigned PARITY_MODE_EVEN = 0;
    localparam int unsigned PARITY_MODE_ODD  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // XOR over the data byte, inverted for odd parity.
    function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_baud_tick.sv
// Bit-time timer: counts clk cycles and flags the last cycle of each bit.
module uart_baud_tick
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [BAUD_CNT_W-1:0] CNT_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_CNT_W-1:0] CNT_ONE  = BAUD_CNT_W'(1);

    logic [BAUD_CNT_W-1:0] count_q;
    logic [BAUD_CNT_W-1:0] count_d;

    assign bit_tick = !clear && (count_q == CNT_LAST);

    // Next count: restart at every bit boundary or while held clear.
    always_comb begin
        count_d = count_q + CNT_ONE;
        if (clear || bit_tick) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter fed from the FIFO read port: pops one byte per frame and
// serialises start, 8 data bits LSB-first, optional parity and stop bit(s).
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = PARITY_MODE_EVEN,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      SYS_reset_n,
    input  logic                      fifo_empty,
    input  logic                      fifo_data_valid,
    input  logic [UART_DATA_BITS-1:0] fifo_data,
    output logic                      fifo_read_request,
    output logic                      tx,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP_IDX = (STOP_BITS > 1);
    localparam logic       ODD_SEL       = (PARITY_ODD != 0);

    tx_state_t                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      parity_q, parity_d;
    logic                      stop_idx_q, stop_idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      read_req;
    logic                      done;
    logic                      bit_tick;
    logic                      baud_clear;

    // The timer only runs while a frame is on the line.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_WAIT);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (SYS_reset_n),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    // The request is decoded from IDLE so the FIFO sees it in the same cycle;
    // it is gated by reset because IDLE is also the reset state.
    assign fifo_read_request = read_req && SYS_reset_n;
    assign tx                = tx_q;
    assign tx_busy           = busy_q;
    assign tx_done           = done;

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        read_req   = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    read_req = 1'b1;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (fifo_data_valid) begin
                    shift_d    = fifo_data;
                    parity_d   = calc_parity(fifo_data, ODD_SEL);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    state_d = ST_DATA;
                end
            end

            // tx already carries the current bit; shift_q[0] holds the next one.
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP_IDX) begin
                        done    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops the line high immediately.
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            parity_q   <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            parity_q   <= parity_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: four instances cover the parity and
// stop-bit variants, one FIFO model feeds whichever instance is selected.
module tb_uart_tx_ctrl;

    localparam int unsigned CPB = 4;
    localparam int unsigned PEN  [4] = '{0, 1, 1, 0};
    localparam int unsigned PODD [4] = '{0, 0, 1, 0};
    localparam int unsigned SB   [4] = '{1, 1, 1, 2};

    typedef struct packed {
        logic [1:0] dut;
        logic [7:0] data;
        logic       par;
        logic [7:0] len;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] f_empty, f_valid, req, tx, busy, done;
    logic [7:0] f_data;

    logic       empty_r = 1'b1;
    logic       valid_r = 1'b0;
    logic [7:0] data_r = 8'h00;
    logic       force_ne = 1'b0;
    logic       req_s = 1'b0;

    logic [7:0] fifo_q[$];
    vec_t       exp_q[$];
    int         gap_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt  = 0;
    int adj_viol = 0;
    int frames_seen = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_ctrl #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PEN[g]),
            .PARITY_ODD  (PODD[g]),
            .STOP_BITS   (SB[g])
        ) u_dut (
            .clk              (clk),
            .SYS_reset_n      (rst_n),
            .fifo_empty       (f_empty[g]),
            .fifo_data_valid  (f_valid[g]),
            .fifo_data        (f_data),
            .fifo_read_request(req[g]),
            .tx               (tx[g]),
            .tx_busy          (busy[g]),
            .tx_done          (done[g])
        );
    end

    // Only the selected instance sees a FIFO; the others see it empty.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            f_empty[i] = (i == int'(sel)) ? (empty_r && !force_ne) : 1'b1;
            f_valid[i] = (i == int'(sel)) ? valid_r : 1'b0;
        end
    end
    assign f_data = data_r;

    // FIFO model: pops on a request sampled mid-cycle, data valid next cycle.
    always @(posedge clk) begin
        valid_r <= 1'b0;
        if (req_s && fifo_q.size() > 0) begin
            data_r  <= fifo_q.pop_front();
            valid_r <= 1'b1;
        end
        empty_r <= (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [63:0] exp_frame(input vec_t r);
        logic [63:0] v;
        logic b;
        int unsigned nbits;
        v = '0;
        nbits = 1 + 8 + PEN[r.dut] + SB[r.dut];
        for (int unsigned k = 0; k < nbits; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= 8) b = r.data[k-1];
            else if (PEN[r.dut] != 0 && k == 9) b = r.par;
            else b = 1'b1;
            for (int unsigned c = 0; c < CPB; c++) v[k*CPB + c] = b;
        end
        return v;
    endfunction

    // Frame monitor: records tx while busy and scores the frame when busy drops.
    logic [63:0] act;
    int  nsamp = 0;
    int  done_cnt = 0;
    int  done_idx = -1;
    int  gap = 0;
    bit  in_frame = 1'b0;
    bit  prev_req = 1'b0;

    task automatic end_frame();
        vec_t r;
        check("frame expected by scoreboard", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() == 0) return;
        r = exp_q.pop_front();
        check($sformatf("frame length %02h", r.data), 64'(nsamp), 64'(r.len));
        check($sformatf("frame bits %02h", r.data), act, exp_frame(r));
        check($sformatf("tx_done count %02h", r.data), 64'(done_cnt), 64'd1);
        check($sformatf("tx_done position %02h", r.data), 64'(done_idx), 64'(r.len) - 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            req_s    = 1'b0;
            prev_req = 1'b0;
            in_frame = 1'b0;
            nsamp    = 0;
            gap      = 0;
        end else begin
            req_s = req[sel];
            if (req[sel]) begin
                req_cnt++;
                if (prev_req) adj_viol++;
            end
            prev_req = req[sel];
            if (busy[sel]) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    nsamp    = 0;
                    act      = '0;
                    done_cnt = 0;
                    done_idx = -1;
                    gap_q.push_back(gap);
                end
                if (nsamp < 64) act[nsamp] = tx[sel];
                if (done[sel]) begin
                    done_cnt++;
                    done_idx = nsamp;
                end
                nsamp++;
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    end_frame();
                    frames_seen++;
                    gap = 0;
                end
                gap++;
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frames_seen < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("frame completed within budget", 64'(frames_seen >= target), 64'd1);
    endtask

    task automatic push_byte(input logic [7:0] d);
        fifo_q.push_back(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   target;
        int   r0;
        int   n;
        int   bad_tx, bad_busy, nreq;

        vecs[0] = '{dut: 2'd0, data: 8'hA5, par: 1'b0, len: 8'd40};
        vecs[1] = '{dut: 2'd1, data: 8'hA5, par: 1'b0, len: 8'd44};
        vecs[2] = '{dut: 2'd1, data: 8'h07, par: 1'b1, len: 8'd44};
        vecs[3] = '{dut: 2'd2, data: 8'hA5, par: 1'b1, len: 8'd44};
        vecs[4] = '{dut: 2'd2, data: 8'h07, par: 1'b0, len: 8'd44};
        vecs[5] = '{dut: 2'd3, data: 8'hFF, par: 1'b0, len: 8'd44};
        target = 0;

        // Reset values on every instance.
        repeat (3) @(negedge clk);
        check("reset tx", 64'(tx), 64'hF);
        check("reset tx_busy", 64'(busy), 64'h0);
        check("reset tx_done", 64'(done), 64'h0);
        check("reset read_request", 64'(req), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frames across the parameter variants.
        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].dut;
            @(posedge clk);
            #1;
            r0 = req_cnt;
            exp_q.push_back(vecs[i]);
            push_byte(vecs[i].data);
            target++;
            wait_frames(target, 200);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("read_request pulses vec %0d", i), 64'(req_cnt - r0), 64'd1);
        end

        // Back-to-back frames from a preloaded FIFO.
        sel = 2'd0;
        @(posedge clk);
        #1;
        gap_q.delete();
        r0 = req_cnt;
        exp_q.push_back('{dut: 2'd0, data: 8'h11, par: 1'b0, len: 8'd40});
        exp_q.push_back('{dut: 2'd0, data: 8'h22, par: 1'b0, len: 8'd40});
        exp_q.push_back('{dut: 2'd0, data: 8'h33, par: 1'b0, len: 8'd40});
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        target += 3;
        wait_frames(target, 400);
        repeat (3) @(posedge clk);
        #1;
        check("back-to-back read_request pulses", 64'(req_cnt - r0), 64'd3);
        check("back-to-back gaps", {32'(gap_q.size()), 16'(gap_q[1]), 16'(gap_q[2])},
              {32'd3, 16'd2, 16'd2});

        // Empty flag low while the FIFO has nothing to give.
        @(posedge clk);
        #1;
        force_ne = 1'b1;
        bad_tx = 0;
        bad_busy = 0;
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) bad_tx++;
            if (busy[0] !== 1'b0) bad_busy++;
            if (req[0] === 1'b1) nreq++;
        end
        force_ne = 1'b0;
        check("empty race tx low cycles", 64'(bad_tx), 64'd0);
        check("empty race busy cycles", 64'(bad_busy), 64'd0);
        check("empty race retry requests", 64'(nreq), 64'd5);

        // Reset during data bit 3; the in-flight byte is lost.
        @(posedge clk);
        #1;
        push_byte(8'h35);
        exp_q.push_back('{dut: 2'd0, data: 8'hC3, par: 1'b0, len: 8'd40});
        push_byte(8'hC3);
        n = 0;
        while (busy[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("frame start before reset", 64'(busy[0]), 64'd1);
        repeat (17) @(negedge clk);
        check("tx on data bit 3 before reset", 64'(tx[0]), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("tx high on async reset", 64'(tx[0]), 64'd1);
        check("tx_busy low on async reset", 64'(busy[0]), 64'd0);
        nreq = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req[0] !== 1'b0) nreq++;
        end
        check("read_request held during reset", 64'(nreq), 64'd0);
        rst_n = 1'b1;
        target++;
        wait_frames(target, 200);

        repeat (5) @(posedge clk);
        #1;
        check("read_request never adjacent", 64'(adj_viol), 64'd0);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
